// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter granting two cache miss handlers whole-line bursts on a single-port word memory.
// Latency: grant one cycle after request in IDLE; read words trail addresses by one cycle.
// Backpressure: a losing or mid-transaction request is held off until the next IDLE slot.
module mem_line_arbiter #(
    parameter int ADDR_LEN   = 11,
    parameter int OFFSET_LEN = 3,
    parameter int LINE_LEN   = ADDR_LEN - OFFSET_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [LINE_LEN-1:0]   line0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [LINE_LEN-1:0]   line1,
    input  logic [31:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  done0,
    output logic                  done1,
    output logic [OFFSET_LEN-1:0] word_idx,
    output logic [31:0]           rdata,
    output logic [ADDR_LEN-1:0]   mem_addr,
    output logic                  mem_wr_req,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data
);
    localparam int LINE_WORDS = 1 << OFFSET_LEN;
    localparam logic [OFFSET_LEN:0] CNT_LAST  = (OFFSET_LEN+1)'(LINE_WORDS);
    localparam logic [OFFSET_LEN:0] CNT_WLAST = CNT_LAST - 1'b1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state;
    logic [OFFSET_LEN:0]   cnt;
    logic                  favour1;
    logic                  own1;
    logic [ADDR_LEN-1:0]   addr_q;
    logic                  win1;
    logic [OFFSET_LEN:0]   cnt_m1;

    // Port 1 wins when it is the only requester or when the pointer favours it.
    assign win1     = req1 && (!req0 || favour1);
    assign cnt_m1   = cnt - 1'b1;
    assign mem_addr = addr_q;
    assign rdata    = mem_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            favour1 <= 1'b0;
            own1    <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            addr_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req0 || req1) begin
                        favour1 <= !win1;
                        own1    <= win1;
                        if (win1) begin
                            gnt1   <= 1'b1;
                            addr_q <= {line1, {OFFSET_LEN{1'b0}}};
                            state  <= we1 ? WRITE : READ;
                        end else begin
                            gnt0   <= 1'b1;
                            addr_q <= {line0, {OFFSET_LEN{1'b0}}};
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    cnt <= cnt + 1'b1;
                    // Offset stops at the last word; the line field never advances.
                    if (cnt < CNT_WLAST)
                        addr_q[OFFSET_LEN-1:0] <= addr_q[OFFSET_LEN-1:0] + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt < CNT_WLAST)
                        addr_q[OFFSET_LEN-1:0] <= addr_q[OFFSET_LEN-1:0] + 1'b1;
                    if (cnt == CNT_WLAST) begin
                        state <= IDLE;
                        gnt1  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs decode straight from registered state, so reset clears them at once.
    always_comb begin
        rvalid0     = 1'b0;
        rvalid1     = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        word_idx    = '0;
        mem_wr_req  = 1'b0;
        mem_wr_data = '0;
        unique case (state)
            READ: begin
                if (cnt != '0) begin
                    word_idx = cnt_m1[OFFSET_LEN-1:0];
                    rvalid0  = !own1;
                    rvalid1  = own1;
                end
                if (cnt == CNT_LAST) begin
                    done0 = !own1;
                    done1 = own1;
                end
            end
            WRITE: begin
                mem_wr_req  = 1'b1;
                word_idx    = cnt[OFFSET_LEN-1:0];
                mem_wr_data = wdata1;
                done1       = (cnt == CNT_WLAST);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with a behavioural memory and per-port read/write scoreboards.
module tb_mem_line_arbiter;
    localparam int ADDR_LEN = 11, OFFSET_LEN = 3, LINE_LEN = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [LINE_LEN-1:0] line0 = '0, line1 = '0;
    logic [31:0] wdata1, rdata, mem_wr_data, mem_rd_data, wbase;
    logic gnt0, gnt1, rvalid0, rvalid1, done0, done1, mem_wr_req;
    logic [OFFSET_LEN-1:0] word_idx;
    logic [ADDR_LEN-1:0] mem_addr;

    logic [31:0] mem    [0:2047];
    logic [31:0] golden [0:2047];

    typedef struct packed { logic [2:0] idx; logic [31:0] d; } rd_t;
    typedef struct packed { logic [10:0] a; logic [31:0] d; } wr_t;
    rd_t q0[$], q1[$];
    wr_t qw[$];
    int  gorder[$];
    rd_t er;
    wr_t ew;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, last_done0 = 0, gap1 = 0, d1_cnt = 0, wr_cycles = 0;
    logic g0_q = 1'b0, g1_q = 1'b0, chk255 = 1'b0, ok;

    assign wdata1 = wbase + 32'(word_idx);

    mem_line_arbiter #(.ADDR_LEN(ADDR_LEN), .OFFSET_LEN(OFFSET_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .line0(line0),
        .req1(req1), .we1(we1), .line1(line1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .done0(done0), .done1(done1), .word_idx(word_idx), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr_req) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops scoreboards on every read/write beat and logs grant order.
    always @(negedge clk) begin
        if (rst_n) begin
            ok = !(gnt0 && gnt1) && (!rvalid0 || gnt0) && (!rvalid1 || gnt1)
                 && (!done0 || gnt0) && (!done1 || gnt1) && (!mem_wr_req || gnt1);
            check("exclusive", ok, 1);
            if (rvalid0) begin
                if (q0.size() == 0) check("rd0_unexpected", 1, 0);
                else begin
                    er = q0.pop_front();
                    check("rd0_idx", word_idx, er.idx);
                    check("rd0_data", rdata, er.d);
                end
            end
            if (rvalid1) begin
                if (q1.size() == 0) check("rd1_unexpected", 1, 0);
                else begin
                    er = q1.pop_front();
                    check("rd1_idx", word_idx, er.idx);
                    check("rd1_data", rdata, er.d);
                end
            end
            if (mem_wr_req) begin
                wr_cycles++;
                if (qw.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    ew = qw.pop_front();
                    check("wr_addr", mem_addr, ew.a);
                    check("wr_data", mem_wr_data, ew.d);
                end
            end
            if (chk255 && gnt1) check("addr_line255", mem_addr >= 11'd2040, 1);
            if (gnt0 && !g0_q) gorder.push_back(0);
            if (gnt1 && !g1_q) begin gorder.push_back(1); gap1 = cyc - last_done0; end
            if (done0) last_done0 = cyc;
            if (done1) d1_cnt++;
        end
        g0_q = gnt0;
        g1_q = gnt1;
    end

    // One whole-line transaction: push expectations, raise req, wait for done, drop, idle a cycle.
    task automatic run_txn(input bit p, input bit we, input logic [7:0] line);
        int t;
        int a;
        for (int i = 0; i < 8; i++) begin
            a = int'({line, 3'(i)});
            if (we) begin
                golden[a] = wbase + 32'(i);
                qw.push_back('{11'(a), wbase + 32'(i)});
            end else if (p) q1.push_back('{3'(i), golden[a]});
            else q0.push_back('{3'(i), golden[a]});
        end
        if (p) begin req1 = 1'b1; we1 = we; line1 = line; end
        else begin req0 = 1'b1; line0 = line; end
        t = 0;
        do begin @(negedge clk); t++; end while (!(p ? done1 : done0) && t < 60);
        check(p ? "done1_seen" : "done0_seen", p ? done1 : done0, 1);
        @(posedge clk); #1;
        if (p) begin req1 = 1'b0; we1 = 1'b0; end else req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int w0, d0;
        logic [31:0] pre [0:7];
        pre = '{32'hd2, 32'h2d, 32'hcc, 32'haf, 32'h7f, 32'h7a, 32'h40, 32'h7b};
        wbase = 32'h0;
        for (int a = 0; a < 2048; a++) begin
            mem[a] = 32'h1000 + 32'(a);
            golden[a] = 32'h1000 + 32'(a);
        end
        for (int a = 0; a < 8; a++) begin mem[a] = pre[a]; golden[a] = pre[a]; end

        #3;
        check("rst_gnt", {gnt0, gnt1, rvalid0, rvalid1, done0, done1, mem_wr_req}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wr_data, 0);
        check("rst_idx", word_idx, 0);
        do_reset();

        // Port-0 read of line 0, cycle by cycle.
        fork
            run_txn(1'b0, 1'b0, 8'd0);
            begin
                @(negedge clk);
                check("c0_gnt0", gnt0, 0);
                for (int k = 1; k <= 9; k++) begin
                    @(negedge clk);
                    check($sformatf("c%0d_gnt0", k), gnt0, 1);
                    check($sformatf("c%0d_addr", k), mem_addr, (k <= 8) ? k - 1 : 7);
                    check($sformatf("c%0d_rvalid0", k), rvalid0, k >= 2);
                    check($sformatf("c%0d_done0", k), done0, k == 9);
                    check($sformatf("c%0d_wr", k), mem_wr_req, 0);
                end
                @(negedge clk);
                check("c10_gnt0", gnt0, 0);
            end
        join

        // Port-1 write of line 3 then read back.
        wbase = 32'hA0;
        w0 = wr_cycles;
        run_txn(1'b1, 1'b1, 8'd3);
        check("wr_cycles_line3", wr_cycles - w0, 8);
        run_txn(1'b1, 1'b0, 8'd3);

        // Simultaneous requests after reset, continuous contention.
        do_reset();
        gorder.delete();
        fork
            begin run_txn(1'b0, 1'b0, 8'd0); run_txn(1'b0, 1'b0, 8'd1); end
            begin run_txn(1'b1, 1'b0, 8'd3); run_txn(1'b1, 1'b0, 8'd2); end
        join
        check("order_len", gorder.size(), 4);
        for (int i = 0; i < 4 && i < gorder.size(); i++)
            check($sformatf("order_%0d", i), gorder[i], i % 2);
        check("gap_contend", gap1, 2);

        // Port-1 request arriving mid-read of port 0.
        gorder.delete();
        fork
            run_txn(1'b0, 1'b0, 8'd1);
            begin repeat (4) @(posedge clk); #1; run_txn(1'b1, 1'b0, 8'd2); end
        join
        check("gap_midread", gap1, 2);
        check("midread_order", (gorder.size() == 2) ? {gorder[0][0], gorder[1][0]} : 2'b11, 2'b01);

        // Port-1 read of the top line.
        d0 = d1_cnt;
        chk255 = 1'b1;
        run_txn(1'b1, 1'b0, 8'd255);
        chk255 = 1'b0;
        check("done1_once", d1_cnt - d0, 1);

        // Reset in the middle of a line-5 write after three words.
        wbase = 32'hC0;
        for (int i = 0; i < 3; i++) begin
            golden[40 + i] = 32'hC0 + 32'(i);
            qw.push_back('{11'(40 + i), 32'hC0 + 32'(i)});
        end
        req1 = 1'b1; we1 = 1'b1; line1 = 8'd5;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_gnt1", gnt1, 0);
        check("abort_wr", mem_wr_req, 0);
        check("abort_done1", done1, 0);
        req1 = 1'b0; we1 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            check($sformatf("mem_%0d", 40 + i), mem[40 + i], (i < 3) ? 32'hC0 + 32'(i) : 32'h1000 + 32'(40 + i));
        @(posedge clk); #1;
        gorder.delete();
        fork
            run_txn(1'b0, 1'b0, 8'd5);
            run_txn(1'b1, 1'b0, 8'd5);
        join
        check("post_rst_first", (gorder.size() > 0) ? gorder[0] : 9, 0);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        check("qw_empty", qw.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
